// File: rtl/dcc_pkg.sv
// Shared DCC encoder definitions: FSM state encoding and default NMRA-style timing constants.
package dcc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } dcc_state_e;

  localparam int DCC_CLK_DIV_DEF   = 4;
  localparam int DCC_ONE_HALF_DEF  = 58;
  localparam int DCC_ZERO_HALF_DEF = 100;
  localparam int DCC_CNT_W_DEF     = 8;

endpackage

// File: rtl/dcc_tick_gen.sv
// Free-running prescaler: tick is high for one clk in every CLK_DIV, on the last count.
module dcc_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  if (CLK_DIV < 2) begin : g_bad_div
    $fatal(1, "dcc_tick_gen: CLK_DIV must be >= 2");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/dcc_bit_stream_encoder.sv
// DCC track encoder: each accepted bit becomes a LOW half then a HIGH half on the
// differential rails; an empty source at a bit boundary is covered by a filler '1'.
module dcc_bit_stream_encoder
  import dcc_pkg::*;
#(
  parameter int CLK_DIV   = DCC_CLK_DIV_DEF,
  parameter int ONE_HALF  = DCC_ONE_HALF_DEF,
  parameter int ZERO_HALF = DCC_ZERO_HALF_DEF,
  parameter int CNT_W     = DCC_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic bit_valid,
  input  logic bit_in,
  output logic bit_ready,
  output logic dcc_p,
  output logic dcc_n,
  output logic underrun,
  output logic busy
);

  if (CLK_DIV < 2 || ONE_HALF < 1 || ZERO_HALF <= ONE_HALF ||
      (CNT_W < 31 && ZERO_HALF >= (1 << CNT_W))) begin : g_bad_params
    $fatal(1, "dcc_bit_stream_encoder: illegal CLK_DIV/ONE_HALF/ZERO_HALF/CNT_W");
  end

  localparam logic [CNT_W-1:0] ONE_LOAD  = CNT_W'(ONE_HALF - 1);
  localparam logic [CNT_W-1:0] ZERO_LOAD = CNT_W'(ZERO_HALF - 1);

  function automatic logic [CNT_W-1:0] half_load(input logic b);
    return b ? ONE_LOAD : ZERO_LOAD;
  endfunction

  dcc_state_e       state;
  logic [CNT_W-1:0] phase;
  logic             cur_bit;
  logic             tick;
  logic             phase_done;
  logic             boundary;
  logic             next_bit;

  dcc_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign phase_done = tick && (phase == '0);
  assign boundary   = ((state == ST_IDLE) && en) || ((state == ST_HIGH) && phase_done);
  // Gated by reset_n so that an asserted reset never advertises readiness from IDLE.
  assign bit_ready  = reset_n && en && boundary;
  assign next_bit   = bit_valid ? bit_in : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      phase    <= '0;
      cur_bit  <= 1'b0;
      dcc_p    <= 1'b0;
      dcc_n    <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (en && boundary) begin
        state    <= ST_LOW;
        cur_bit  <= next_bit;
        phase    <= half_load(next_bit);
        dcc_p    <= 1'b0;
        dcc_n    <= 1'b1;
        busy     <= 1'b1;
        underrun <= !bit_valid;
      end else begin
        case (state)
          ST_LOW: begin
            if (tick) begin
              if (phase == '0) begin
                state <= ST_HIGH;
                phase <= half_load(cur_bit);
                dcc_p <= 1'b1;
                dcc_n <= 1'b0;
              end else begin
                phase <= phase - CNT_W'(1);
              end
            end
          end
          ST_HIGH: begin
            // A finished HIGH half with en low parks the track; otherwise keep counting.
            if (tick) begin
              if (phase == '0) begin
                state <= ST_IDLE;
                phase <= '0;
                dcc_p <= 1'b0;
                dcc_n <= 1'b0;
                busy  <= 1'b0;
              end else begin
                phase <= phase - CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcc_bit_stream_encoder.sv
// Bench for dcc_bit_stream_encoder: cycle-level schedule model plus directed run-length checks.
module tb_dcc_bit_stream_encoder;

  localparam int CLK_DIV   = 4;
  localparam int ONE_HALF  = 3;
  localparam int ZERO_HALF = 5;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic bit_ready, dcc_p, dcc_n, underrun, busy;

  int checks = 0;
  int errors = 0;

  dcc_bit_stream_encoder #(
    .CLK_DIV   (CLK_DIV),
    .ONE_HALF  (ONE_HALF),
    .ZERO_HALF (ZERO_HALF),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .dcc_p     (dcc_p),
    .dcc_n     (dcc_n),
    .underrun  (underrun),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bit starting at boundary cycle b has its LOW half end on the h-th
  // prescaler tick after b (ticks fall on cycles k%CLK_DIV == CLK_DIV-1), and its
  // HIGH half lasts exactly h*CLK_DIV cycles after that.
  int k = 0;
  bit m_busy = 0;
  bit m_under = 0;
  int m_low_last = 0;
  int m_high_last = 0;
  int m_h = 0;

  function automatic int low_end(input int b, input int h);
    int nt;
    nt = b + 1 + (CLK_DIV - 1 - ((b + 1) % CLK_DIV));
    return nt + (h - 1) * CLK_DIV;
  endfunction

  function automatic bit m_boundary();
    return (!m_busy && en) || (m_busy && k == m_high_last);
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      k = 0; m_busy = 0; m_under = 0; m_low_last = 0; m_high_last = 0;
    end else begin
      if (en && m_boundary()) begin
        m_h = (bit_valid ? bit_in : 1'b1) ? ONE_HALF : ZERO_HALF;
        m_low_last  = low_end(k, m_h);
        m_high_last = m_low_last + m_h * CLK_DIV;
        m_under = !bit_valid;
        m_busy = 1;
      end else begin
        m_under = 0;
        if (m_busy && k == m_high_last) m_busy = 0;
      end
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk1("rst_p", dcc_p, 1'b0);
      chk1("rst_n", dcc_n, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_under", underrun, 1'b0);
      chk1("rst_ready", bit_ready, 1'b0);
    end else begin
      chk1("dcc_p", dcc_p, m_busy && (k > m_low_last));
      chk1("dcc_n", dcc_n, m_busy && (k <= m_low_last));
      chk1("busy", busy, m_busy);
      chk1("underrun", underrun, m_under);
      chk1("bit_ready", bit_ready, en && m_boundary());
    end
  end

  // Run-length monitor: entries are 1000+len for LOW halves, 2000+len for HIGH halves.
  int runs[$];
  int run_len = 0;
  int prev_lvl = 0;
  int xfers = 0;
  int under_cnt = 0;

  initial forever begin
    int lvl;
    @(negedge clk);
    lvl = dcc_p ? 2 : (dcc_n ? 1 : 0);
    if (lvl != prev_lvl) begin
      if (prev_lvl != 0) runs.push_back(prev_lvl * 1000 + run_len);
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_lvl = lvl;
    if (reset_n && bit_ready && bit_valid) xfers++;
    if (underrun) under_cnt++;
  end

  bit q[$];
  bit toggle = 0;

  task automatic load_inputs();
    if (toggle) begin
      bit_valid = 1'b1;
      bit_in = ~bit_in;
    end else begin
      bit_valid = (q.size() > 0);
      bit_in = (q.size() > 0) ? q[0] : 1'b0;
    end
  endtask

  task automatic step();
    bit x;
    @(negedge clk);
    x = reset_n && bit_ready && bit_valid;
    @(posedge clk);
    #1;
    if (x && q.size() > 0) void'(q.pop_front());
    load_inputs();
  endtask

  task automatic clear_stats();
    runs.delete();
    xfers = 0;
    under_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy; i++) step();
    chk1(name, busy, 1'b0);
  endtask

  int exp1[9] = '{2012, 1012, 2012, 1020, 2020, 1020, 2020, 1012, 2012};
  int bad;

  initial begin
    repeat (3) step();
    reset_n = 1'b1;
    #1;
    chk1("post_rst_p", dcc_p, 1'b0);
    chk1("post_rst_n", dcc_n, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
    chk1("post_rst_under", underrun, 1'b0);
    chk1("post_rst_ready", bit_ready, 1'b0);
    repeat (5) step();

    // Stream 1,1,0,0,1: the leading '1' absorbs the variable first-LOW length.
    clear_stats();
    q = '{1, 1, 0, 0, 1};
    load_inputs();
    en = 1'b1;
    for (int i = 0; i < 400 && q.size() > 0; i++) step();
    chkn("s1_q_drained", q.size(), 0);
    en = 1'b0;
    wait_idle("s1_idle");
    step();
    chkn("s1_nruns", runs.size(), 10);
    chk1("s1_first_low", (runs[0] >= 1009) && (runs[0] <= 1012), 1'b1);
    for (int i = 0; i < 9; i++) chkn("s1_run", runs[i + 1], exp1[i]);
    chkn("s1_xfers", xfers, 5);
    chkn("s1_under", under_cnt, 0);

    // Underrun: one '0', empty source at the next boundary, then a late '0'.
    clear_stats();
    q = '{0};
    load_inputs();
    en = 1'b1;
    for (int i = 0; i < 400 && !underrun; i++) step();
    chk1("s2_under_seen", underrun, 1'b1);
    q.push_back(1'b0);
    load_inputs();
    for (int i = 0; i < 400 && q.size() > 0; i++) step();
    chkn("s2_q_drained", q.size(), 0);
    en = 1'b0;
    wait_idle("s2_idle");
    step();
    chkn("s2_nruns", runs.size(), 6);
    chk1("s2_first_low", (runs[0] >= 1017) && (runs[0] <= 1020), 1'b1);
    chkn("s2_run1", runs[1], 2020);
    chkn("s2_filler_low", runs[2], 1012);
    chkn("s2_filler_high", runs[3], 2012);
    chkn("s2_run4", runs[4], 1020);
    chkn("s2_run5", runs[5], 2020);
    chkn("s2_under_cycles", under_cnt, 1);
    chkn("s2_xfers", xfers, 2);

    // en dropped 3 clk into HIGH of a '0' bit with another bit pending.
    clear_stats();
    q = '{0, 1};
    load_inputs();
    en = 1'b1;
    for (int i = 0; i < 400 && !dcc_p; i++) step();
    chk1("s3_high_seen", dcc_p, 1'b1);
    repeat (3) step();
    en = 1'b0;
    wait_idle("s3_idle");
    step();
    chkn("s3_last_high", runs[runs.size() - 1], 2020);
    chkn("s3_pending_kept", q.size(), 1);
    chkn("s3_xfers", xfers, 1);
    chk1("s3_idle_p", dcc_p, 1'b0);
    chk1("s3_idle_n", dcc_n, 1'b0);
    q.delete();
    load_inputs();
    repeat (4) step();

    // bit_in toggling every cycle with bit_valid held high.
    clear_stats();
    toggle = 1;
    load_inputs();
    en = 1'b1;
    repeat (150) step();
    en = 1'b0;
    wait_idle("s4_idle");
    toggle = 0;
    load_inputs();
    step();
    bad = 0;
    for (int i = 1; i < runs.size(); i++)
      if ((runs[i] % 1000) != 12 && (runs[i] % 1000) != 20) bad++;
    chkn("s4_bad_runs", bad, 0);
    chk1("s4_xfers", xfers >= 4, 1'b1);

    // Reset asserted mid-LOW of a '0' bit, en still high.
    clear_stats();
    q = '{0};
    load_inputs();
    en = 1'b1;
    for (int i = 0; i < 400 && !dcc_n; i++) step();
    chk1("s5_low_seen", dcc_n, 1'b1);
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk1("s5_rst_p", dcc_p, 1'b0);
    chk1("s5_rst_n", dcc_n, 1'b0);
    chk1("s5_rst_busy", busy, 1'b0);
    chk1("s5_rst_ready", bit_ready, 1'b0);
    repeat (3) step();
    en = 1'b0;
    reset_n = 1'b1;
    repeat (10) step();
    chk1("s5_after_p", dcc_p, 1'b0);
    chk1("s5_after_n", dcc_n, 1'b0);
    chk1("s5_after_busy", busy, 1'b0);
    q = '{1};
    load_inputs();
    en = 1'b1;
    #1;
    chk1("s5_first_ready", bit_ready, 1'b1);
    step();
    chkn("s5_taken", q.size(), 0);
    en = 1'b0;
    wait_idle("s5_idle");
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
